// File: rtl/char_buffer_pkg.sv
// char_buffer_pkg: command encodings, default geometry and FSM state type for char_buffer_scroll.
package char_buffer_pkg;
   localparam int CMD_W = 3;
   localparam logic [CMD_W-1:0] CMD_NOP         = 3'd0;
   localparam logic [CMD_W-1:0] CMD_SCROLL_UP   = 3'd1;
   localparam logic [CMD_W-1:0] CMD_SCROLL_DOWN = 3'd2;
   localparam logic [CMD_W-1:0] CMD_CLEAR_EOL   = 3'd3;
   localparam logic [CMD_W-1:0] CMD_CLEAR_EOS   = 3'd4;
   localparam logic [CMD_W-1:0] CMD_CLEAR_ALL   = 3'd5;
   localparam int DEF_COLS = 80;
   localparam int DEF_ROWS = 25;
   typedef enum logic {IDLE, FILL} state_t;
endpackage

// File: rtl/char_buffer_scroll_if.sv
// char_buffer_scroll_if: host write, scan-out read and command handshake bundle.
interface char_buffer_scroll_if
   import char_buffer_pkg::*;
#(
   parameter int ROW_BITS = $clog2(DEF_ROWS),
   parameter int COL_BITS = $clog2(DEF_COLS),
   parameter int DATA_W   = 8
);
   logic [ROW_BITS-1:0] wr_row;
   logic [COL_BITS-1:0] wr_col;
   logic [DATA_W-1:0]   din;
   logic                write_en;
   logic [ROW_BITS-1:0] rd_row;
   logic [COL_BITS-1:0] rd_col;
   logic                read_en;
   logic [DATA_W-1:0]   dout;
   logic                cmd_valid;
   logic [CMD_W-1:0]    cmd;
   logic [ROW_BITS-1:0] cmd_row;
   logic [COL_BITS-1:0] cmd_col;
   logic                cmd_ready;
   logic [ROW_BITS-1:0] top_row;
   modport master (
      output wr_row, wr_col, din, write_en, rd_row, rd_col, read_en,
             cmd_valid, cmd, cmd_row, cmd_col,
      input  dout, cmd_ready, top_row
   );
   modport slave (
      input  wr_row, wr_col, din, write_en, rd_row, rd_col, read_en,
             cmd_valid, cmd, cmd_row, cmd_col,
      output dout, cmd_ready, top_row
   );
endinterface

// File: rtl/char_ram.sv
// char_ram: simple dual-port 1W1R synchronous RAM with registered read
module char_ram #(
  parameter int DEPTH = 2000,
  parameter int DATA_W = 8,
  parameter INIT_FILE = "",
  parameter int A_BITS = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [A_BITS-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [A_BITS-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/char_buffer_scroll.sv
// char_buffer_scroll: ROWS x COLS character RAM with circular-offset scroll and a one-cell-per-clock fill engine.
// Optional SCROLL_DOWN command enabled by defining CHAR_BUFFER_SCROLL_DOWN_EN.
module char_buffer_scroll
   import char_buffer_pkg::*;
#(
   parameter int COLS   = DEF_COLS,
   parameter int ROWS   = DEF_ROWS,
   parameter int DATA_W = 8,
   parameter logic [DATA_W-1:0] FILL_CHAR = 8'h20,
   parameter     INIT_FILE = ""
) (
   input logic clk,
   input logic reset_n,
   char_buffer_scroll_if.slave bus
);
   localparam int ROW_BITS = $clog2(ROWS);
   localparam int COL_BITS = $clog2(COLS);
   localparam int DEPTH    = ROWS * COLS;
   localparam int A_BITS   = $clog2(DEPTH);
   localparam logic [ROW_BITS:0]   ROWS_W   = (ROW_BITS+1)'(ROWS);
   localparam logic [COL_BITS:0]   COLS_W   = (COL_BITS+1)'(COLS);
   localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
   localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
   state_t state, state_n;
   logic [ROW_BITS-1:0] top, top_n, f_row, f_row_n, f_end, f_end_n;
   logic [COL_BITS-1:0] f_col, f_col_n;
   logic idle, wr_ok, rd_oor, cmd_ok, rd_seen, oor_q, ram_we;
   logic [A_BITS-1:0] ram_waddr, ram_raddr;
   logic [DATA_W-1:0] ram_wdata, ram_q;
   // Logical row is rotated by top; sum < 2*ROWS so one subtract replaces the mod.
   function automatic logic [A_BITS-1:0] addr_of(input logic [ROW_BITS-1:0] r,
                                                  input logic [COL_BITS-1:0] c,
                                                  input logic [ROW_BITS-1:0] t);
      logic [ROW_BITS:0] s;
      s = {1'b0, r} + {1'b0, t};
      s = (s >= ROWS_W) ? s - ROWS_W : s;
      return A_BITS'(s[ROW_BITS-1:0]) * A_BITS'(COLS) + A_BITS'(c);
   endfunction
   assign idle      = (state == IDLE);
   assign wr_ok     = idle && bus.write_en && ({1'b0, bus.wr_row} < ROWS_W) && ({1'b0, bus.wr_col} < COLS_W);
   assign rd_oor    = ({1'b0, bus.rd_row} >= ROWS_W) || ({1'b0, bus.rd_col} >= COLS_W);
   assign cmd_ok    = ({1'b0, bus.cmd_row} < ROWS_W) && ({1'b0, bus.cmd_col} < COLS_W);
   assign ram_we    = wr_ok || !idle;
   assign ram_waddr = idle ? addr_of(bus.wr_row, bus.wr_col, top) : addr_of(f_row, f_col, top);
   assign ram_wdata = idle ? bus.din : FILL_CHAR;
   assign ram_raddr = addr_of(bus.rd_row, bus.rd_col, top);
   char_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .INIT_FILE(INIT_FILE)) u_ram (
      .clk(clk), .we(ram_we), .waddr(ram_waddr), .wdata(ram_wdata),
      .re(bus.read_en && !rd_oor), .raddr(ram_raddr), .rdata(ram_q)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_seen <= 1'b0;
         oor_q   <= 1'b0;
      end else if (bus.read_en) begin
         rd_seen <= 1'b1;
         oor_q   <= rd_oor;
      end
   end
   assign bus.dout      = !rd_seen ? '0 : oor_q ? FILL_CHAR : ram_q;
   assign bus.cmd_ready = idle;
   assign bus.top_row   = top;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         top   <= '0;
         f_row <= '0;
         f_col <= '0;
         f_end <= '0;
      end else begin
         state <= state_n;
         top   <= top_n;
         f_row <= f_row_n;
         f_col <= f_col_n;
         f_end <= f_end_n;
      end
   end
   // Every fill ends at LAST_COL of f_end, so only the end row needs storing.
   always_comb begin
      state_n = state;
      top_n   = top;
      f_row_n = f_row;
      f_col_n = f_col;
      f_end_n = f_end;
      if (idle) begin
         if (bus.cmd_valid) begin
            case (bus.cmd)
               CMD_SCROLL_UP: begin
                  state_n = FILL;
                  top_n   = (top == LAST_ROW) ? '0 : top + ROW_BITS'(1);
                  f_row_n = LAST_ROW;
                  f_col_n = '0;
                  f_end_n = LAST_ROW;
               end
`ifdef CHAR_BUFFER_SCROLL_DOWN_EN
               CMD_SCROLL_DOWN: begin
                  state_n = FILL;
                  top_n   = (top == '0) ? LAST_ROW : top - ROW_BITS'(1);
                  f_row_n = '0;
                  f_col_n = '0;
                  f_end_n = '0;
               end
`endif
               CMD_CLEAR_EOL, CMD_CLEAR_EOS: begin
                  state_n = cmd_ok ? FILL : IDLE;
                  f_row_n = bus.cmd_row;
                  f_col_n = bus.cmd_col;
                  f_end_n = (bus.cmd == CMD_CLEAR_EOL) ? bus.cmd_row : LAST_ROW;
               end
               CMD_CLEAR_ALL: begin
                  state_n = FILL;
                  f_row_n = '0;
                  f_col_n = '0;
                  f_end_n = LAST_ROW;
               end
               default: ;
            endcase
         end
      end else begin
         f_col_n = (f_col == LAST_COL) ? '0 : f_col + COL_BITS'(1);
         f_row_n = (f_col == LAST_COL) ? f_row + ROW_BITS'(1) : f_row;
         state_n = (f_col == LAST_COL && f_row == f_end) ? IDLE : FILL;
      end
   end
endmodule

// File: tb/tb_char_buffer_scroll.sv
// tb_char_buffer_scroll: directed and random checks against a logical-screen model that physically moves rows on scroll.
module tb_char_buffer_scroll;
   import char_buffer_pkg::*;
   localparam int R = 25;
   localparam int C = 80;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;
   char_buffer_scroll_if #(.ROW_BITS(5), .COL_BITS(7), .DATA_W(8)) bus ();
   char_buffer_scroll dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   logic [7:0] scr [R][C];
   int mtop = 0;
   int checks = 0;
   int errors = 0;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [7:0] mread(input int r, input int c);
      return (r >= R || c >= C) ? 8'h20 : scr[r][c];
   endfunction
   task automatic do_read(input int r, input int c, input string tag);
      logic [7:0] e;
      e = mread(r, c);
      bus.rd_row = 5'(r);
      bus.rd_col = 7'(c);
      bus.read_en = 1'b1;
      tick;
      bus.read_en = 1'b0;
      check(tag, 32'(bus.dout), 32'(e));
   endtask
   task automatic do_write(input int r, input int c, input logic [7:0] d);
      logic idle;
      idle = bus.cmd_ready;
      bus.wr_row = 5'(r);
      bus.wr_col = 7'(c);
      bus.din = d;
      bus.write_en = 1'b1;
      tick;
      bus.write_en = 1'b0;
      if (idle && r < R && c < C) scr[r][c] = d;
   endtask
   function automatic int exp_busy(input int c, input int r, input int col);
      logic ok;
      ok = (r < R) && (col < C);
      case (c)
         1: return C;
`ifdef CHAR_BUFFER_SCROLL_DOWN_EN
         2: return C;
`endif
         3: return ok ? C - col : 0;
         4: return ok ? (C - col) + (R - 1 - r) * C : 0;
         5: return R * C;
         default: return 0;
      endcase
   endfunction
   task automatic fill_cells(input int r0, input int c0, input int n);
      for (int i = 0; i < n; i++) begin
         int p;
         p = r0 * C + c0 + i;
         scr[p / C][p % C] = 8'h20;
      end
   endtask
   task automatic model_cmd(input int c, input int r, input int col);
      if (c == 1) begin
         for (int i = 0; i < R - 1; i++)
            for (int j = 0; j < C; j++) scr[i][j] = scr[i+1][j];
         fill_cells(R - 1, 0, C);
         mtop = (mtop + 1) % R;
      end
`ifdef CHAR_BUFFER_SCROLL_DOWN_EN
      if (c == 2) begin
         for (int i = R - 1; i > 0; i--)
            for (int j = 0; j < C; j++) scr[i][j] = scr[i-1][j];
         fill_cells(0, 0, C);
         mtop = (mtop + R - 1) % R;
      end
`endif
      if (c == 3 || c == 4) fill_cells(r, col, exp_busy(c, r, col));
      if (c == 5) fill_cells(0, 0, R * C);
   endtask
   task automatic issue(input int c, input int r, input int col);
      bus.cmd = 3'(c);
      bus.cmd_row = 5'(r);
      bus.cmd_col = 7'(col);
      bus.cmd_valid = 1'b1;
      tick;
      bus.cmd_valid = 1'b0;
   endtask
   task automatic wait_ready(output int n);
      n = 0;
      while (!bus.cmd_ready && n < 3000) begin
         n++;
         tick;
      end
   endtask
   task automatic run_cmd(input int c, input int r, input int col, input string tag);
      int n, e;
      e = exp_busy(c, r, col);
      issue(c, r, col);
      wait_ready(n);
      model_cmd(c, r, col);
      check({tag, "_busy"}, 32'(n), 32'(e));
      check({tag, "_top"}, 32'(bus.top_row), 32'(mtop));
   endtask
   initial begin
      int n;
      logic [7:0] tmp [R][C];
      bus.wr_row = '0; bus.wr_col = '0; bus.din = '0; bus.write_en = 1'b0;
      bus.rd_row = '0; bus.rd_col = '0; bus.read_en = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd = '0; bus.cmd_row = '0; bus.cmd_col = '0;
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++) scr[i][j] = 8'h20;
      #2 reset_n = 1'b0;
      repeat (2) tick;
      check("rst_dout", 32'(bus.dout), 32'h0);
      check("rst_ready", 32'(bus.cmd_ready), 32'h1);
      check("rst_top", 32'(bus.top_row), 32'h0);
      reset_n = 1'b1;
      tick;
      run_cmd(5, 0, 0, "init_clear_all");
      do_write(0, 0, 8'h41);
      do_read(0, 0, "rd_00");
      tick;
      check("dout_hold", 32'(bus.dout), 32'h41);
      do_read(25, 0, "rd_oor_row");
      do_read(3, 90, "rd_oor_col");
      do_write(2, 2, 8'h11);
      bus.wr_row = 5'd2; bus.wr_col = 7'd2; bus.din = 8'h22; bus.write_en = 1'b1;
      bus.rd_row = 5'd2; bus.rd_col = 7'd2; bus.read_en = 1'b1;
      tick;
      bus.write_en = 1'b0; bus.read_en = 1'b0;
      check("rw_collision_old", 32'(bus.dout), 32'h11);
      scr[2][2] = 8'h22;
      do_read(2, 2, "rw_collision_new");
      do_write(1, 5, 8'h42);
      run_cmd(1, 0, 0, "scroll_up");
      do_read(0, 5, "scrolled_cell");
      for (int j = 0; j < C; j++) do_read(24, j, "bottom_row_fill");
      do_write(1, 3, 8'h55);
      bus.wr_row = 5'd1; bus.wr_col = 7'd3; bus.din = 8'h77; bus.write_en = 1'b1;
      bus.cmd = 3'd1; bus.cmd_valid = 1'b1;
      tick;
      bus.write_en = 1'b0; bus.cmd_valid = 1'b0;
      scr[1][3] = 8'h77;
      wait_ready(n);
      model_cmd(1, 0, 0);
      check("wr_cmd_busy", 32'(n), 32'd80);
      check("wr_cmd_top", 32'(bus.top_row), 32'(mtop));
      do_read(0, 3, "wr_cmd_cell");
      do_write(0, 0, 8'h66);
      issue(1, 0, 0);
      do_write(0, 0, 8'h99);
      wait_ready(n);
      model_cmd(1, 0, 0);
      check("busy_write_rest", 32'(n), 32'd79);
      do_read(0, 0, "busy_write_dropped");
      while (mtop != 0) run_cmd(1, 0, 0, "scroll_wrap");
      check("top_wrapped", 32'(bus.top_row), 32'h0);
      do_write(1, 19, 8'h5B);
      do_write(1, 20, 8'h5A);
      issue(5, 0, 0);
      repeat (100) tick;
      reset_n = 1'b0;
      #1;
      check("abort_ready", 32'(bus.cmd_ready), 32'h1);
      check("abort_top", 32'(bus.top_row), 32'h0);
      check("abort_dout", 32'(bus.dout), 32'h0);
      fill_cells(0, 0, 100);
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++) tmp[i][j] = scr[(i - mtop + R) % R][j];
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++) scr[i][j] = tmp[i][j];
      mtop = 0;
      #2 reset_n = 1'b1;
      do_read(1, 19, "abort_last_filled");
      do_read(1, 20, "abort_untouched");
      do_read(0, 0, "abort_first_filled");
      do_write(3, 69, 8'h69);
      do_write(3, 70, 8'h70);
      run_cmd(3, 3, 70, "clear_eol");
      do_read(3, 69, "eol_preserved");
      for (int j = 70; j < C; j++) do_read(3, j, "eol_filled");
      do_write(23, 77, 8'h37);
      do_write(23, 78, 8'h38);
      do_write(24, 0, 8'h40);
      run_cmd(4, 23, 78, "clear_eos");
      do_read(23, 77, "eos_preserved");
      do_read(23, 78, "eos_start");
      do_read(24, 0, "eos_next_row");
      run_cmd(3, 25, 0, "eol_bad_row");
      run_cmd(4, 0, 80, "eos_bad_col");
      run_cmd(0, 0, 0, "nop");
      run_cmd(6, 0, 0, "unused6");
      run_cmd(7, 0, 0, "unused7");
      do_write(0, 1, 8'h31);
      do_write(24, 1, 8'h32);
      run_cmd(2, 0, 0, "scroll_down");
      do_read(0, 1, "sd_row0");
      do_read(1, 1, "sd_row1");
      do_read(24, 1, "sd_row24");
      for (int i = 0; i < 400; i++) begin
         int op;
         op = int'($urandom_range(0, 19));
         if (op < 8) do_write(int'($urandom_range(0, 27)), int'($urandom_range(0, 83)), 8'($urandom));
         else if (op < 17) do_read(int'($urandom_range(0, 31)), int'($urandom_range(0, 127)), "rand_read");
         else run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 26)), int'($urandom_range(0, 82)), "rand_cmd");
      end
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++) do_read(i, j, "final_scan");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
